// File: rtl/assignment_two_top_level.sv
// ---------------------------------------------------------------------------
// assignment_two_top_level
//
// Program-counter subsystem for the RAT-style CPU. A four-way next-address
// multiplexer feeds a loadable, incrementing PC register whose value
// addresses the instruction ROM.
//
// Ports:
//    CLK        - system clock, all state changes on the rising edge
//    RST        - synchronous reset, active-low (clears the PC)
//    FROM_IMMED - branch/call target from the instruction immediate field
//    FROM_STACK - return address popped from the stack
//    PC_MUX_SEL - next-address select (0 immed, 1 stack, 2 vector, 3 zero)
//    PC_LD      - load the mux output into the PC
//    PC_INC     - increment the PC by one
//    PC_COUNT   - current PC value, straight from the register
// ---------------------------------------------------------------------------
module assignment_two_top_level #(
   parameter int               WIDTH    = 10,
   parameter logic [WIDTH-1:0] INTR_VEC = 10'h3FF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] FROM_IMMED,
   input  logic [WIDTH-1:0] FROM_STACK,
   input  logic [1:0]       PC_MUX_SEL,
   input  logic             PC_LD,
   input  logic             PC_INC,
   output logic [WIDTH-1:0] PC_COUNT
);

   logic [WIDTH-1:0] muxOut;
   logic [WIDTH-1:0] pcCount_d;
   logic [WIDTH-1:0] pcCount_q;

   // Next-address selection. The reserved select value drives zero so the
   // PC can never pick up an unknown value from an unused mux leg.
   always_comb begin
      muxOut = '0;
      case (PC_MUX_SEL)
         2'd0:    muxOut = FROM_IMMED;
         2'd1:    muxOut = FROM_STACK;
         2'd2:    muxOut = INTR_VEC;
         default: muxOut = '0;
      endcase
   end

   // Load wins over increment; with neither the PC holds. The increment
   // simply wraps at the top of the address space, no carry is kept.
   always_comb begin
      pcCount_d = pcCount_q;
      if (PC_LD) begin
         pcCount_d = muxOut;
      end else if (PC_INC) begin
         pcCount_d = pcCount_q + WIDTH'(1);
      end
   end

   // PC register. Reset is sampled on the clock edge only, so a low pulse
   // on RST that ends before the next rising edge leaves the PC untouched.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         pcCount_q <= '0;
      end else begin
         pcCount_q <= pcCount_d;
      end
   end

   assign PC_COUNT = pcCount_q;

endmodule

// File: tb/tb_assignment_two_top_level.sv
// ---------------------------------------------------------------------------
// tb_assignment_two_top_level
//
// Self-checking bench for the PC subsystem. A table of per-edge stimulus
// records with expected PC values is applied in a loop; expected values are
// queued when the stimulus is driven and popped when the PC is sampled just
// after the clock edge. A few hand-written sequences cover reset timing.
// ---------------------------------------------------------------------------
module tb_assignment_two_top_level;

   localparam int WIDTH = 10;

   logic             CLK;
   logic             RST;
   logic [WIDTH-1:0] FROM_IMMED;
   logic [WIDTH-1:0] FROM_STACK;
   logic [1:0]       PC_MUX_SEL;
   logic             PC_LD;
   logic             PC_INC;
   logic [WIDTH-1:0] PC_COUNT;

   typedef struct {
      logic             rst;
      logic             ld;
      logic             inc;
      logic [1:0]       sel;
      logic [WIDTH-1:0] immed;
      logic [WIDTH-1:0] stack;
      logic [WIDTH-1:0] expPc;
      string            name;
   } vec_t;

   vec_t             vecs[$];
   logic [WIDTH-1:0] expQ[$];
   int               checks = 0;
   int               errors = 0;

   assignment_two_top_level #(
      .WIDTH    (WIDTH),
      .INTR_VEC (10'h3FF)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .FROM_IMMED (FROM_IMMED),
      .FROM_STACK (FROM_STACK),
      .PC_MUX_SEL (PC_MUX_SEL),
      .PC_LD      (PC_LD),
      .PC_INC     (PC_INC),
      .PC_COUNT   (PC_COUNT)
   );

   // 10 time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Safety net so the run always ends even if something stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic addVec(input logic rst, input logic ld, input logic inc,
                         input logic [1:0] sel, input logic [WIDTH-1:0] immed,
                         input logic [WIDTH-1:0] stack,
                         input logic [WIDTH-1:0] expPc, input string name);
      vec_t v;
      v.rst   = rst;
      v.ld    = ld;
      v.inc   = inc;
      v.sel   = sel;
      v.immed = immed;
      v.stack = stack;
      v.expPc = expPc;
      v.name  = name;
      vecs.push_back(v);
   endtask

   // Pop the oldest expected value and compare it with the PC right now.
   task automatic checkOutput(input string name);
      logic [WIDTH-1:0] exp;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, got %h", name, PC_COUNT);
      end else begin
         exp = expQ.pop_front();
         if (PC_COUNT !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, PC_COUNT, exp);
         end
      end
   endtask

   // Drive one record on the falling edge, let one rising edge sample it,
   // then check the PC shortly after that edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge CLK);
      RST        = v.rst;
      PC_LD      = v.ld;
      PC_INC     = v.inc;
      PC_MUX_SEL = v.sel;
      FROM_IMMED = v.immed;
      FROM_STACK = v.stack;
      expQ.push_back(v.expPc);
      @(posedge CLK);
      #1;
      checkOutput(v.name);
   endtask

   initial begin
      RST        = 1'b0;
      PC_LD      = 1'b1;
      PC_INC     = 1'b1;
      PC_MUX_SEL = 2'd0;
      FROM_IMMED = 10'h003;
      FROM_STACK = 10'h0B5;

      //      rst   ld    inc   sel   immed    stack    expect
      addVec(1'b0, 1'b1, 1'b1, 2'd0, 10'h003, 10'h0B5, 10'h000, "reset_edge1");
      addVec(1'b0, 1'b1, 1'b1, 2'd0, 10'h003, 10'h0B5, 10'h000, "reset_edge2");
      addVec(1'b1, 1'b1, 1'b0, 2'd0, 10'h003, 10'h0B5, 10'h003, "load_immed");
      addVec(1'b1, 1'b1, 1'b0, 2'd1, 10'h003, 10'h0B5, 10'h0B5, "load_stack");
      addVec(1'b1, 1'b1, 1'b0, 2'd2, 10'h003, 10'h0B5, 10'h3FF, "load_vector");
      addVec(1'b1, 1'b1, 1'b0, 2'd3, 10'h003, 10'h0B5, 10'h000, "load_reserved");
      addVec(1'b1, 1'b1, 1'b0, 2'd2, 10'h003, 10'h0B5, 10'h3FF, "load_vector2");
      addVec(1'b1, 1'b0, 1'b1, 2'd2, 10'h003, 10'h0B5, 10'h000, "inc_wrap");
      addVec(1'b1, 1'b0, 1'b1, 2'd2, 10'h003, 10'h0B5, 10'h001, "inc_after_wrap");
      addVec(1'b1, 1'b0, 1'b0, 2'd0, 10'h155, 10'h2AA, 10'h001, "hold_1");
      addVec(1'b1, 1'b0, 1'b0, 2'd1, 10'h0AA, 10'h123, 10'h001, "hold_2");
      addVec(1'b1, 1'b0, 1'b0, 2'd2, 10'h3C3, 10'h03C, 10'h001, "hold_3");
      addVec(1'b1, 1'b1, 1'b0, 2'd0, 10'h010, 10'h0B5, 10'h010, "load_0x010");
      addVec(1'b1, 1'b1, 1'b1, 2'd1, 10'h010, 10'h0B5, 10'h0B5, "ld_beats_inc");
      addVec(1'b0, 1'b1, 1'b1, 2'd1, 10'h010, 10'h0B5, 10'h000, "rst_beats_ld_inc");
      addVec(1'b1, 1'b0, 1'b1, 2'd0, 10'h010, 10'h0B5, 10'h001, "inc_from_zero");
      addVec(1'b1, 1'b0, 1'b1, 2'd3, 10'h010, 10'h0B5, 10'h002, "inc_again");
      addVec(1'b1, 1'b1, 1'b0, 2'd0, 10'h3FE, 10'h0B5, 10'h3FE, "load_0x3FE");
      addVec(1'b1, 1'b0, 1'b1, 2'd0, 10'h3FE, 10'h0B5, 10'h3FF, "inc_to_top");
      addVec(1'b1, 1'b0, 1'b1, 2'd0, 10'h3FE, 10'h0B5, 10'h000, "inc_top_wrap");
      addVec(1'b1, 1'b1, 1'b0, 2'd1, 10'h3FE, 10'h2A5, 10'h2A5, "load_stack2");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
      end

      // Reset glitch between edges: RST goes low after a rising edge and is
      // released before the next one, so the PC must keep 0x2A5.
      @(negedge CLK);
      PC_LD  = 1'b0;
      PC_INC = 1'b0;
      RST    = 1'b1;
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      expQ.push_back(10'h2A5);
      checkOutput("glitch_mid_cycle");
      #3;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      expQ.push_back(10'h2A5);
      checkOutput("glitch_no_effect");

      // RST low across an edge with INC set: PC stays put until the edge,
      // then clears; after release with INC it counts from zero.
      @(negedge CLK);
      RST    = 1'b0;
      PC_INC = 1'b1;
      #1;
      expQ.push_back(10'h2A5);
      checkOutput("rst_low_before_edge");
      @(posedge CLK);
      #1;
      expQ.push_back(10'h000);
      checkOutput("rst_across_edge");
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      expQ.push_back(10'h001);
      checkOutput("count_after_release");

      // Select change without load must not reach the PC.
      @(negedge CLK);
      PC_INC     = 1'b0;
      PC_MUX_SEL = 2'd2;
      @(posedge CLK);
      #1;
      expQ.push_back(10'h001);
      checkOutput("sel_change_no_load");

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
